// File: rtl/pll_clock_sequencer_if.sv
// Core-facing signals of the PLL start-up sequencer.
// The sequencer sits on the slave side and drives reset, run status and the phi2 enable.
interface pll_clock_sequencer_if;
    logic       ce_hold;
    logic       sys_reset;
    logic       running;
    logic       clock_enable;
    logic [7:0] lock_loss_count;

    modport master (
        output ce_hold,
        input  sys_reset,
        input  running,
        input  clock_enable,
        input  lock_loss_count
    );

    modport slave (
        input  ce_hold,
        output sys_reset,
        output running,
        output clock_enable,
        output lock_loss_count
    );
endinterface

// File: rtl/pll_clock_sequencer.sv
// Holds the SID core in reset until the PLL is stably locked.
// Afterwards it generates the ~1 MHz phi2 enable from a phase-accumulator NCO.
module pll_clock_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned ACC_WIDTH     = 24,
    parameter int unsigned PHASE_INC     = 333876
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 locked,
    pll_clock_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } state_e;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [ACC_WIDTH:0] INC = (ACC_WIDTH + 1)'(PHASE_INC);

    state_e               state_q, state_d;
    logic                 sync1_q, locked_s_q;
    logic [15:0]          cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ce_q, ce_d;
    logic [7:0]           llc_q, llc_d;
    logic [ACC_WIDTH:0]   sum;

    // locked is asynchronous to clock
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= locked;
            locked_s_q <= sync1_q;
        end
    end

    assign sum = {1'b0, acc_q} + INC;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ce_d    = 1'b0;
        llc_d   = llc_q;
        unique case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                acc_d = '0;
                if (locked_s_q) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                acc_d = '0;
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RUN: begin
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                    acc_d   = '0;
                    if (llc_q != 8'hFF) begin
                        llc_d = llc_q + 8'd1;
                    end
                end else if (!bus.ce_hold) begin
                    acc_d = sum[ACC_WIDTH-1:0];
                    ce_d  = sum[ACC_WIDTH];
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
                acc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            acc_q   <= '0;
            ce_q    <= 1'b0;
            llc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ce_q    <= ce_d;
            llc_q   <= llc_d;
        end
    end

    assign bus.sys_reset       = (state_q != RUN);
    assign bus.running         = (state_q == RUN);
    assign bus.clock_enable    = ce_q;
    assign bus.lock_loss_count = llc_q;

endmodule

// File: tb/tb_pll_clock_sequencer.sv
// Bench for pll_clock_sequencer: vector table, directed start-up/loss/hold/reset
// sequences and a randomised run against a lock-streak / phase-count model.
module tb_pll_clock_sequencer;

    localparam int     SC  = 16;
    localparam int     AW  = 24;
    localparam longint INC = 333876;
    localparam longint MOD = longint'(1) << AW;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic locked = 1'b0;

    pll_clock_sequencer_if bus();

    pll_clock_sequencer #(.SETTLE_CYCLES(SC)) dut (
        .clock  (clock),
        .reset  (reset),
        .locked (locked),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int errs = 0;

    // Model: sync pipeline of lock samples, streak of consecutive synced-lock
    // edges, count of non-hold RUN edges since RUN entry.
    bit     m_s1, m_s2;
    int     m_streak;
    longint m_n;
    bit     m_ce;
    int     m_llc;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_run();
        return m_streak > SC;
    endfunction

    function automatic void model_step(input bit rst, input bit lk, input bit hold);
        bit ls;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_streak = 0; m_n = 0; m_ce = 0; m_llc = 0;
            return;
        end
        ls = m_s2;
        m_ce = 0;
        if (m_run()) begin
            if (!ls) begin
                if (m_llc < 255) m_llc++;
                m_n = 0;
                m_streak = 0;
            end else if (!hold) begin
                m_n++;
                m_ce = ((m_n * INC) >> AW) != (((m_n - 1) * INC) >> AW);
            end
        end else begin
            m_n = 0;
            m_streak = ls ? m_streak + 1 : 0;
        end
        m_s2 = m_s1;
        m_s1 = lk;
    endfunction

    task automatic tick(input bit rst, input bit lk, input bit hold);
        reset = rst;
        locked = lk;
        bus.ce_hold = hold;
        @(posedge clock);
        model_step(rst, lk, hold);
        #1;
        chk("running", bus.running, m_run());
        chk("sys_reset", bus.sys_reset, !m_run());
        chk("clock_enable", bus.clock_enable, m_ce);
        chk("lock_loss_count", bus.lock_loss_count, m_llc);
        chk("acc", dut.acc_q, (m_n * INC) % MOD);
    endtask

    task automatic go_run(output int cyc);
        cyc = 0;
        do begin
            tick(0, 1, 0);
            cyc++;
        end while (!bus.running && cyc < 200);
        chk("go_run_timeout", bus.running, 1);
    endtask

    task automatic lose_lock(output int cyc);
        cyc = 0;
        do begin
            tick(0, 0, 0);
            cyc++;
        end while (!bus.sys_reset && cyc < 20);
        chk("lose_lock_timeout", bus.sys_reset, 1);
    endtask

    typedef struct {
        bit rst;
        bit lk;
        bit hold;
        bit exp_run;
        bit exp_ce;
    } vec_t;

    vec_t tbl[40];

    initial begin
        int c, p, first, last, sp, bad_sp;
        longint exp_p;
        int drop_left;
        bit lk, hd, rs;

        bus.ce_hold = 1'b0;
        m_s1 = 0; m_s2 = 0; m_streak = 0; m_n = 0; m_ce = 0; m_llc = 0;

        // Start-up vectors: lock sampled from edge 10, running from edge 28
        for (int i = 0; i < 40; i++) begin
            tbl[i].rst     = (i < 3);
            tbl[i].lk      = (i >= 10);
            tbl[i].hold    = 0;
            tbl[i].exp_run = (i >= 28);
            tbl[i].exp_ce  = 0;
        end
        for (int i = 0; i < 40; i++) begin
            tick(tbl[i].rst, tbl[i].lk, tbl[i].hold);
            chk("tbl_running", bus.running, tbl[i].exp_run);
            chk("tbl_sys_reset", bus.sys_reset, !tbl[i].exp_run);
            chk("tbl_ce", bus.clock_enable, tbl[i].exp_ce);
            chk("tbl_llc", bus.lock_loss_count, 0);
        end

        // NCO rate, pulse width and spacing from a fresh RUN entry
        tick(1, 0, 0);
        tick(1, 0, 0);
        go_run(c);
        p = 0; first = -1; last = -1; bad_sp = 0;
        for (int i = 1; i <= 50250; i++) begin
            tick(0, 1, 0);
            if (bus.clock_enable) begin
                p++;
                if (first < 0) first = i;
                else begin
                    sp = i - last;
                    if (sp < 50 || sp > 51) bad_sp++;
                end
                last = i;
            end
        end
        chk("nco_pulse_count", p, 1000);
        chk("nco_first_pulse", first, 51);
        chk("nco_bad_spacing", bad_sp, 0);

        // Lock glitch during SETTLE restarts the full settle period
        tick(1, 0, 0);
        tick(1, 0, 0);
        for (int i = 0; i < 13; i++) tick(0, 1, 0);
        chk("glitch_not_run", bus.running, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0);
        go_run(c);
        chk("glitch_resettle_cycles", c, 19);
        chk("glitch_llc", bus.lock_loss_count, 0);

        // Lock loss in RUN, then saturation of the loss counter
        lose_lock(c);
        chk("loss_latency_ok", (c >= 2 && c <= 3), 1);
        chk("loss_llc_1", bus.lock_loss_count, 1);
        for (int r = 1; r < 300; r++) begin
            go_run(c);
            lose_lock(c);
        end
        chk("loss_llc_sat", bus.lock_loss_count, 255);

        // ce_hold freezes the phase
        tick(1, 0, 0);
        go_run(c);
        for (int i = 0; i < 30; i++) tick(0, 1, 0);
        chk("hold_acc_pre", dut.acc_q, (30 * INC) % MOD);
        p = 0;
        for (int i = 0; i < 200; i++) begin
            tick(0, 1, 1);
            if (bus.clock_enable) p++;
        end
        chk("hold_pulses", p, 0);
        chk("hold_acc_post", dut.acc_q, (30 * INC) % MOD);
        for (int i = 0; i < 300; i++) begin
            tick(0, 1, 0);
            if (bus.clock_enable) p++;
        end
        exp_p = ((330 * INC) >> AW) - ((30 * INC) >> AW);
        chk("hold_resume_pulses", p, exp_p);

        // Reset in RUN clears counters; full settle repeats
        tick(1, 0, 0);
        go_run(c);
        for (int r = 0; r < 5; r++) begin
            lose_lock(c);
            go_run(c);
        end
        chk("rst_llc_5", bus.lock_loss_count, 5);
        for (int i = 0; i < 20; i++) tick(0, 1, 0);
        tick(1, 1, 0);
        chk("rst_sys_reset", bus.sys_reset, 1);
        chk("rst_running", bus.running, 0);
        chk("rst_llc", bus.lock_loss_count, 0);
        chk("rst_acc", dut.acc_q, 0);
        go_run(c);
        chk("rst_resettle_cycles", c, 19);

        // Randomised lock glitches, holds and resets
        drop_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (drop_left > 0) begin
                lk = 0;
                drop_left--;
            end else begin
                lk = 1;
                if ($urandom_range(0, 79) == 0) drop_left = $urandom_range(1, 5);
            end
            hd = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 1499) == 0);
            tick(rs, lk, hd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, errs);
        $finish;
    end

endmodule
